// File: rtl/bram_add_seq.sv
// Sequencer for the BRAM adder: reads A[i] and B[i] from one single-port BRAM, feeds the
// external adder and writes the sum back to the destination region under the adder's enable.
module bram_add_seq #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_a_base_i,
  input  logic [ADDR_W-1:0] src_b_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] wr_count_o,
  output logic              bram_en_o,
  output logic [3:0]        bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [31:0]       bram_din_o,
  input  logic [31:0]       bram_dout_i,
  output logic [31:0]       add_a_o,
  output logic [31:0]       add_b_o,
  input  logic [31:0]       add_c_i,
  input  logic [3:0]        add_web_i
);

  typedef enum logic [2:0] {StIdle, StRdA, StWtA, StRdB, StWtB, StWr, StDone} state_e;

  localparam logic [1:0] LastWait = 2'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic [1:0]          wait_q, wait_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   a_base_q, a_base_d;
  logic [ADDR_W-1:0]   b_base_q, b_base_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   wr_count_q, wr_count_d;
  logic [31:0]         add_a_q, add_a_d;
  logic [31:0]         add_b_q, add_b_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      idx_q      <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      wr_count_q <= '0;
      add_a_q    <= '0;
      add_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      idx_q      <= idx_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      wr_count_q <= wr_count_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    a_base_d    = a_base_q;
    b_base_d    = b_base_q;
    dst_d       = dst_q;
    len_d       = len_q;
    wr_count_d  = wr_count_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    bram_en_o   = 1'b0;
    bram_we_o   = 4'b0000;
    bram_addr_o = '0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_base_d   = src_a_base_i;
          b_base_d   = src_b_base_i;
          dst_d      = dst_base_i;
          len_d      = len_i;
          wr_count_d = '0;
          idx_d      = '0;
          wait_d     = '0;
          state_d    = (len_i == '0) ? StDone : StRdA;
        end
      end
      StRdA: begin
        busy_o      = 1'b1;
        bram_en_o   = 1'b1;
        bram_addr_o = a_base_q + idx_q;
        state_d     = StWtA;
      end
      StWtA: begin
        busy_o = 1'b1;
        if (wait_q == LastWait) begin
          add_a_d = bram_dout_i;
          wait_d  = '0;
          state_d = StRdB;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StRdB: begin
        busy_o      = 1'b1;
        bram_en_o   = 1'b1;
        bram_addr_o = b_base_q + idx_q;
        state_d     = StWtB;
      end
      StWtB: begin
        busy_o = 1'b1;
        if (wait_q == LastWait) begin
          add_b_d = bram_dout_i;
          wait_d  = '0;
          state_d = StWr;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StWr: begin
        busy_o      = 1'b1;
        bram_en_o   = 1'b1;
        bram_addr_o = dst_q + idx_q;
        bram_we_o   = {4{|add_web_i}};
        if (|add_web_i) wr_count_d = wr_count_q + ADDR_W'(1);
        idx_d   = idx_q + ADDR_W'(1);
        // idx is compared before the increment takes effect
        state_d = (idx_q == len_q - ADDR_W'(1)) ? StDone : StRdA;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign wr_count_o = wr_count_q;
  assign add_a_o    = add_a_q;
  assign add_b_o    = add_b_q;
  assign bram_din_o = add_c_i;

endmodule

// File: tb/tb_bram_add_seq.sv
// Bench for bram_add_seq: two instances (read latency 1 and 2) with BRAM and adder models.
module tb_bram_add_seq;

  localparam logic [31:0] Sent = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [9:0]        a;
    logic [9:0]        b;
    logic [9:0]        d;
    logic [9:0]        n;
    logic [0:2][31:0]  av;
    logic [0:2][31:0]  bv;
    logic [0:2][31:0]  ec;
    logic [9:0]        wc;
    int                busy;
    int                rs;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Preload port shared by both memory models
  logic        pl_we = 1'b0;
  logic        pl_sel = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  // Instance 1: RD_LAT = 1
  logic        start1 = 1'b0;
  logic [9:0]  a1 = '0, b1 = '0, d1 = '0, n1 = '0;
  logic        busy1, done1, en1;
  logic [9:0]  wc1, addr1;
  logic [3:0]  we1, web1;
  logic [31:0] din1, dout1, adda1, addb1, addc1;
  logic [31:0] mem1 [0:1023];

  bram_add_seq #(.ADDR_W(10), .RD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1),
    .src_a_base_i(a1), .src_b_base_i(b1), .dst_base_i(d1), .len_i(n1),
    .busy_o(busy1), .done_o(done1), .wr_count_o(wc1),
    .bram_en_o(en1), .bram_we_o(we1), .bram_addr_o(addr1), .bram_din_o(din1),
    .bram_dout_i(dout1), .add_a_o(adda1), .add_b_o(addb1),
    .add_c_i(addc1), .add_web_i(web1)
  );

  assign addc1 = adda1 + addb1;
  assign web1  = (adda1 != 32'd0) ? 4'hF : 4'h0;

  always @(posedge clk) begin
    if (pl_we && !pl_sel) mem1[pl_addr] <= pl_data;
    else if (en1) begin
      for (int j = 0; j < 4; j++) if (we1[j]) mem1[addr1][8*j +: 8] <= din1[8*j +: 8];
      dout1 <= mem1[addr1];
    end
  end

  // Instance 2: RD_LAT = 2
  logic        start2 = 1'b0;
  logic [9:0]  a2 = '0, b2 = '0, d2 = '0, n2 = '0;
  logic        busy2, done2, en2;
  logic [9:0]  wc2, addr2;
  logic [3:0]  we2, web2;
  logic [31:0] din2, dout2, rd2_q, adda2, addb2, addc2;
  logic [31:0] mem2 [0:1023];

  bram_add_seq #(.ADDR_W(10), .RD_LAT(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2),
    .src_a_base_i(a2), .src_b_base_i(b2), .dst_base_i(d2), .len_i(n2),
    .busy_o(busy2), .done_o(done2), .wr_count_o(wc2),
    .bram_en_o(en2), .bram_we_o(we2), .bram_addr_o(addr2), .bram_din_o(din2),
    .bram_dout_i(dout2), .add_a_o(adda2), .add_b_o(addb2),
    .add_c_i(addc2), .add_web_i(web2)
  );

  assign addc2 = adda2 + addb2;
  assign web2  = (adda2 != 32'd0) ? 4'hF : 4'h0;

  always @(posedge clk) begin
    dout2 <= rd2_q;
    if (pl_we && pl_sel) mem2[pl_addr] <= pl_data;
    else if (en2) begin
      for (int j = 0; j < 4; j++) if (we2[j]) mem2[addr2][8*j +: 8] <= din2[8*j +: 8];
      rd2_q <= mem2[addr2];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_mem(input logic sel, input logic [9:0] addr, input logic [31:0] data);
    @(negedge clk);
    pl_sel  = sel;
    pl_addr = addr;
    pl_data = data;
    pl_we   = 1'b1;
    @(negedge clk);
    pl_we   = 1'b0;
  endtask

  task automatic preload1(input vec_t v);
    for (int k = 0; k < 3; k++) wr_mem(1'b0, v.d + 10'(k), Sent);
    for (int k = 0; k < 3; k++) if (k < int'(v.n)) wr_mem(1'b0, v.a + 10'(k), v.av[k]);
    for (int k = 0; k < 3; k++) if (k < int'(v.n)) wr_mem(1'b0, v.b + 10'(k), v.bv[k]);
  endtask

  task automatic run1(input int id, input vec_t v);
    int bc, ec, dk;
    logic [9:0] da;
    preload1(v);
    @(negedge clk);
    a1 = v.a; b1 = v.b; d1 = v.d; n1 = v.n;
    start1 = 1'b1;
    bc = 0; ec = 0; dk = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start1 = (k == v.rs);
      if (k == v.rs) begin
        a1 = 10'd200; b1 = 10'd210; d1 = 10'd220; n1 = 10'd1;
      end
      if (busy1) bc++;
      if (en1) ec++;
      if (done1) begin
        dk = k;
        break;
      end
    end
    start1 = 1'b0;
    if (dk < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL v%0d timeout: got no done, expected done within 200 cycles", id);
    end else begin
      chk($sformatf("v%0d done_cycle", id), dk, v.busy);
      chk($sformatf("v%0d busy_cycles", id), bc, v.busy);
      chk($sformatf("v%0d en_cycles", id), ec, 3 * int'(v.n));
      chk($sformatf("v%0d wr_count", id), {22'd0, wc1}, {22'd0, v.wc});
      @(negedge clk);
      chk($sformatf("v%0d done_width", id), {31'd0, done1}, 32'd0);
      for (int k = 0; k < 3; k++) begin
        da = v.d + 10'(k);
        chk($sformatf("v%0d mem[%0d]", id, da), mem1[da], v.ec[k]);
      end
    end
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{a:10'd0, b:10'd16, d:10'd32, n:10'd3,
                av:'{32'd5, 32'd0, 32'd1}, bv:'{32'd7, 32'd9, 32'd2},
                ec:'{32'd12, Sent, 32'd3}, wc:10'd2, busy:15, rs:-1};
    vecs[1] = '{a:10'd100, b:10'd110, d:10'd120, n:10'd0,
                av:'{32'd0, 32'd0, 32'd0}, bv:'{32'd0, 32'd0, 32'd0},
                ec:'{Sent, Sent, Sent}, wc:10'd0, busy:0, rs:-1};
    vecs[2] = '{a:10'd0, b:10'd16, d:10'd32, n:10'd3,
                av:'{32'd5, 32'd0, 32'd1}, bv:'{32'd7, 32'd9, 32'd2},
                ec:'{32'd12, Sent, 32'd3}, wc:10'd2, busy:15, rs:4};
    vecs[3] = '{a:10'd40, b:10'd50, d:10'd40, n:10'd2,
                av:'{32'd1, 32'd2, 32'd0}, bv:'{32'd10, 32'd20, 32'd0},
                ec:'{32'd11, 32'd22, Sent}, wc:10'd2, busy:10, rs:-1};
    vecs[4] = '{a:10'd60, b:10'd70, d:10'd1023, n:10'd2,
                av:'{32'd3, 32'd4, 32'd0}, bv:'{32'd4, 32'hFFFF_FFFF, 32'd0},
                ec:'{32'd7, 32'd3, Sent}, wc:10'd2, busy:10, rs:-1};

    // Reset state
    #12;
    chk("rst busy", {31'd0, busy1}, 32'd0);
    chk("rst done", {31'd0, done1}, 32'd0);
    chk("rst en", {31'd0, en1}, 32'd0);
    chk("rst we", {28'd0, we1}, 32'd0);
    chk("rst addr", {22'd0, addr1}, 32'd0);
    chk("rst add_a", adda1, 32'd0);
    chk("rst add_b", addb1, 32'd0);
    chk("rst wr_count", {22'd0, wc1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run1(i, vecs[i]);

    // Reset during WT_B of element 1 aborts with no write for that element
    begin
      vec_t v;
      v = vecs[0];
      v.av = '{32'd5, 32'd6, 32'd1};
      preload1(v);
      @(negedge clk);
      a1 = v.a; b1 = v.b; d1 = v.d; n1 = v.n;
      start1 = 1'b1;
      for (int k = 0; k <= 8; k++) begin
        @(negedge clk);
        start1 = 1'b0;
      end
      chk("abort pre busy", {31'd0, busy1}, 32'd1);
      chk("abort pre en", {31'd0, en1}, 32'd0);
      rst = 1'b1;
      #1;
      chk("abort busy", {31'd0, busy1}, 32'd0);
      chk("abort add_a", adda1, 32'd0);
      chk("abort wr_count", {22'd0, wc1}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      begin
        int ec;
        ec = 0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (en1) ec++;
        end
        chk("abort idle en", ec, 0);
      end
      chk("abort mem[32]", mem1[32], 32'd12);
      chk("abort mem[33]", mem1[33], Sent);
      run1(5, vecs[0]);
    end

    // RD_LAT=2 with source A wrapping past the top of the address space
    begin
      int bc, dk;
      wr_mem(1'b1, 10'd1023, 32'd5);
      wr_mem(1'b1, 10'd0, 32'd6);
      wr_mem(1'b1, 10'd16, 32'd7);
      wr_mem(1'b1, 10'd17, 32'd8);
      wr_mem(1'b1, 10'd32, Sent);
      wr_mem(1'b1, 10'd33, Sent);
      @(negedge clk);
      a2 = 10'd1023; b2 = 10'd16; d2 = 10'd32; n2 = 10'd2;
      start2 = 1'b1;
      bc = 0; dk = -1;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        start2 = 1'b0;
        if (k == 0) chk("lat2 first A addr", {21'd0, en2, addr2}, {21'd0, 1'b1, 10'd1023});
        if (k == 7) chk("lat2 second A addr", {21'd0, en2, addr2}, {21'd0, 1'b1, 10'd0});
        if (busy2) bc++;
        if (done2) begin
          dk = k;
          break;
        end
      end
      if (dk < 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL lat2 timeout: got no done, expected done within 200 cycles");
      end else begin
        chk("lat2 done_cycle", dk, 14);
        chk("lat2 busy_cycles", bc, 14);
        chk("lat2 wr_count", {22'd0, wc2}, 32'd2);
        chk("lat2 mem[32]", mem2[32], 32'd12);
        chk("lat2 mem[33]", mem2[33], 32'd14);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
